adc_nch_scan_seq: RTL

//  Parametrised N-channel successor to the 8-channel serial ADC front end. Drives an external

---
 rtl/adc_seq_pkg.sv | 47 ++++
 rtl/adc_sclk_shift.sv | 79 +++++++
 rtl/adc_nch_scan_seq.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/adc_seq_pkg.sv
// Shared types and channel-mask helpers for the N-channel ADC scan sequencer.
// Latency: combinational helpers only.
// Backpressure: none.
package adc_seq_pkg;

  localparam int MAX_CH = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CONV,
    NEXT
  } state_t;

  // Channel selection result: vld=0 means no qualifying bit was found.
  typedef struct packed {
    logic       vld;
    logic [4:0] idx;
  } ch_sel_t;

  // Lowest set bit of mask strictly above cur.
  function automatic ch_sel_t next_ch(input logic [MAX_CH-1:0] mask, input logic [4:0] cur);
    ch_sel_t r;
    r = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) begin
        r.vld = 1'b1;
        r.idx = 5'(i);
      end
    end
    return r;
  endfunction

  // Lowest set bit of mask.
  function automatic ch_sel_t first_ch(input logic [MAX_CH-1:0] mask);
    ch_sel_t r;
    r = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        r.vld = 1'b1;
        r.idx = 5'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/adc_sclk_shift.sv
// Serial ADC frame engine: SCLK divider, DOUT capture shift register, DIN address serialiser.
// Latency: FRAME*2*SCLK_DIV cycles from start_i to the done_o cycle; result_o valid during done_o.
// Backpressure: none; a frame always runs to completion once started.
module adc_sclk_shift
  import adc_seq_pkg::*;
#(
  parameter int RES      = 12,
  parameter int FRAME    = 16,
  parameter int SCLK_DIV = 2,
  parameter int CH_W     = 3
) (
  input  logic            adc_clk,
  input  logic            rst_l,
  input  logic            start_i,
  input  logic [CH_W-1:0] addr_i,
  input  logic            dout_i,
  output logic            sclk_o,
  output logic            din_o,
  output logic            done_o,
  output logic [RES-1:0]  result_o
);

  localparam int PH_W  = $clog2(2 * SCLK_DIV);
  localparam int PER_W = $clog2(FRAME + 1);
  localparam logic [PH_W-1:0]  PH_RISE  = PH_W'(SCLK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * SCLK_DIV - 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(FRAME - 1);

  logic              run_q;
  logic [PH_W-1:0]   ph_q;
  logic [PER_W-1:0]  per_q;
  logic              sclk_q;
  logic [CH_W-1:0]   din_sh_q;
  logic [RES-1:0]    sh_q;

  // Period phase/bit counters; SCLK rises mid-period, DOUT captured on that same edge,
  // DIN shifted at the falling edge so it is stable while SCLK is high.
  always_ff @(posedge adc_clk or negedge rst_l) begin
    if (!rst_l) begin
      run_q    <= 1'b0;
      ph_q     <= '0;
      per_q    <= '0;
      sclk_q   <= 1'b0;
      din_sh_q <= '0;
      sh_q     <= '0;
    end else if (start_i) begin
      run_q    <= 1'b1;
      ph_q     <= '0;
      per_q    <= '0;
      sclk_q   <= 1'b0;
      din_sh_q <= addr_i;
    end else if (run_q) begin
      if (ph_q == PH_RISE) begin
        sclk_q <= 1'b1;
        sh_q   <= RES'({sh_q, dout_i});
      end
      if (ph_q == PH_LAST) begin
        ph_q   <= '0;
        sclk_q <= 1'b0;
        if (per_q == PER_LAST) begin
          run_q    <= 1'b0;
          per_q    <= '0;
          din_sh_q <= '0;
        end else begin
          per_q    <= per_q + 1'b1;
          din_sh_q <= din_sh_q << 1;
        end
      end else begin
        ph_q <= ph_q + 1'b1;
      end
    end
  end

  assign sclk_o   = sclk_q;
  assign din_o    = din_sh_q[CH_W-1];
  assign done_o   = run_q && (ph_q == PH_LAST) && (per_q == PER_LAST);
  assign result_o = sh_q;

endmodule

// File: rtl/adc_nch_scan_seq.sv
// N-channel mux + serial SAR scan sequencer with optional per-channel oversampling.
// Latency: sync -> first sample in 2 + 2^AVG_LOG2*(SETTLE_CYC + FRAME*2*SCLK_DIV) cycles.
// Backpressure: none; samples are one-cycle strobes, sync while busy is dropped and flagged.
module adc_nch_scan_seq #(
  parameter int N_CH       = 8,
  parameter int CH_W       = $clog2(N_CH),
  parameter int RES        = 12,
  parameter int FRAME      = 16,
  parameter int SCLK_DIV   = 2,
  parameter int SETTLE_CYC = 8,
  parameter int AVG_LOG2   = 0
) (
  input  logic            adc_clk,
  input  logic            rst_l,
  input  logic            sync,
  input  logic            cont_en,
  input  logic [N_CH-1:0] ch_mask,
  input  logic            ovr_clr,
  input  logic            DOUT,
  output logic            SCLK,
  output logic            CS_ADC,
  output logic [CH_W-1:0] CD_MUX,
  output logic            DIN,
  output logic            s_valid,
  output logic [RES-1:0]  s_data,
  output logic [CH_W-1:0] s_ch,
  output logic            s_last,
  output logic            busy,
  output logic            overrun
);
  import adc_seq_pkg::*;

  localparam int ACC_W = RES + AVG_LOG2;
  localparam int SC_W  = $clog2(SETTLE_CYC + 1);
  localparam logic [SC_W-1:0] SC_LAST   = SC_W'(SETTLE_CYC - 1);
  localparam logic [4:0]      NCONV_LAST = 5'((1 << AVG_LOG2) - 1);

  state_t            state_q, state_d;
  logic [SC_W-1:0]   cnt_q, cnt_d;
  logic [4:0]        nconv_q, nconv_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [N_CH-1:0]   mask_q, mask_d;
  logic [CH_W-1:0]   cd_q, cd_d;
  logic [CH_W-1:0]   sch_q, sch_d;
  logic [RES-1:0]    sdata_q, sdata_d;
  logic              sv_q, sv_d;
  logic              slast_q, slast_d;
  logic              busy_q, cs_q;
  logic              ovr_q, ovr_d;
  logic              start, done;
  logic [RES-1:0]    result;
  ch_sel_t           nxt, first;

  assign nxt   = next_ch(32'(mask_q), 5'(cd_q));
  assign first = first_ch(32'(ch_mask));

  // Sticky overrun: a dropped sync beats a simultaneous clear.
  assign ovr_d = (sync && (state_q != IDLE)) ? 1'b1 : (ovr_clr ? 1'b0 : ovr_q);

  // Scan FSM next state, accumulator and sample formation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nconv_d = nconv_q;
    acc_d   = acc_q;
    mask_d  = mask_q;
    cd_d    = cd_q;
    sv_d    = 1'b0;
    sdata_d = sdata_q;
    sch_d   = sch_q;
    slast_d = 1'b0;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if ((sync || cont_en) && first.vld) begin
          mask_d  = ch_mask;
          cd_d    = CH_W'(first.idx);
          cnt_d   = '0;
          nconv_d = '0;
          acc_d   = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == SC_LAST) begin
          start   = 1'b1;
          state_d = CONV;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CONV: begin
        if (done) begin
          acc_d = acc_q + ACC_W'(result);
          cnt_d = '0;
          if (nconv_q == NCONV_LAST) begin
            state_d = NEXT;
          end else begin
            nconv_d = nconv_q + 1'b1;
            state_d = SETTLE;
          end
        end
      end
      NEXT: begin
        sv_d    = 1'b1;
        sdata_d = RES'(acc_q >> AVG_LOG2);
        sch_d   = cd_q;
        slast_d = !nxt.vld;
        acc_d   = '0;
        nconv_d = '0;
        cnt_d   = '0;
        if (nxt.vld) begin
          cd_d    = CH_W'(nxt.idx);
          state_d = SETTLE;
        end else if (cont_en && first.vld) begin
          mask_d  = ch_mask;
          cd_d    = CH_W'(first.idx);
          state_d = SETTLE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered pin outputs.
  always_ff @(posedge adc_clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      nconv_q <= '0;
      acc_q   <= '0;
      mask_q  <= '0;
      cd_q    <= '0;
      sch_q   <= '0;
      sdata_q <= '0;
      sv_q    <= 1'b0;
      slast_q <= 1'b0;
      busy_q  <= 1'b0;
      cs_q    <= 1'b1;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nconv_q <= nconv_d;
      acc_q   <= acc_d;
      mask_q  <= mask_d;
      cd_q    <= cd_d;
      sch_q   <= sch_d;
      sdata_q <= sdata_d;
      sv_q    <= sv_d;
      slast_q <= slast_d;
      busy_q  <= (state_d != IDLE);
      cs_q    <= (state_d != CONV);
      ovr_q   <= ovr_d;
    end
  end

  adc_sclk_shift #(
    .RES      (RES),
    .FRAME    (FRAME),
    .SCLK_DIV (SCLK_DIV),
    .CH_W     (CH_W)
  ) u_shift (
    .adc_clk  (adc_clk),
    .rst_l    (rst_l),
    .start_i  (start),
    .addr_i   (cd_q),
    .dout_i   (DOUT),
    .sclk_o   (SCLK),
    .din_o    (DIN),
    .done_o   (done),
    .result_o (result)
  );

  assign CS_ADC  = cs_q;
  assign CD_MUX  = cd_q;
  assign s_valid = sv_q;
  assign s_data  = sdata_q;
  assign s_ch    = sch_q;
  assign s_last  = slast_q;
  assign busy    = busy_q;
  assign overrun = ovr_q;

endmodule
